// File: rtl/rc4_prga_decrypt.sv
// RC4 pseudo-random generation and decrypt stage.
//
// Runs after the KSA shuffle stage. It walks MSG_LEN bytes of ciphertext,
// advances the RC4 keystream through the shared S memory, and writes each
// plaintext byte to the decrypted-message RAM. It also reports whether every
// plaintext byte is a lowercase letter or a space, for the key-search
// controller.
//
// Memory timing: all three memories are synchronous. An address that the FSM
// registers on one clock edge is captured by the memory on the next edge, so
// its read data (s_q / enc_q) can be sampled by the FSM on the edge after
// that. Each state below registers its outputs on the edge that leaves it.
//
// state  | meaning
// -------+-----------------------------------------------------------------
// IDLE   | waiting for start, no writes
// RD_SI  | issue S[i] read and ciphertext[k] read
// WT_SI  | memory latency
// RD_SJ  | latch si and enc_byte, j += si, issue S[j] read
// WT_SJ  | memory latency
// WR_SI  | latch sj, write S[i] = sj
// WR_SJ  | write S[j] = si
// RD_F   | issue S[si+sj] read
// WT_F   | memory latency
// WR_DEC | write plaintext[k], fold byte into ok, next byte or DONE
// DONE   | finish=1, key_ok=ok, waits for rst or a new start
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   start           begin decryption (sampled in IDLE or DONE)
//   s_address/s_data/s_wren, s_q       S memory port
//   enc_address, enc_q                 ciphertext ROM port
//   dec_address/dec_data/dec_wren      plaintext RAM port
//   finish          high in DONE
//   key_ok          valid while finish=1; all plaintext in {0x20, 0x61..0x7A}

module rc4_prga_decrypt #(
  parameter int MSG_LEN = 32,
  parameter int K_W     = 5
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  output logic [7:0]     s_address,
  output logic [7:0]     s_data,
  output logic           s_wren,
  input  logic [7:0]     s_q,
  output logic [K_W-1:0] enc_address,
  input  logic [7:0]     enc_q,
  output logic [K_W-1:0] dec_address,
  output logic [7:0]     dec_data,
  output logic           dec_wren,
  output logic           finish,
  output logic           key_ok
);

  typedef enum logic [3:0] {
    IDLE, RD_SI, WT_SI, RD_SJ, WT_SJ, WR_SI, WR_SJ, RD_F, WT_F, WR_DEC, DONE
  } state_t;

  localparam logic [K_W-1:0] LAST_K = K_W'(MSG_LEN - 1);

  state_t         state;
  logic [7:0]     i;
  logic [7:0]     j;
  logic [7:0]     si;
  logic [7:0]     sj;
  logic [7:0]     enc_byte;
  logic [K_W-1:0] k;
  logic           ok;

  logic [7:0]     plain;
  logic           plain_ok;

  // In WR_DEC, s_q holds S[si+sj], the keystream byte.
  assign plain    = s_q ^ enc_byte;
  assign plain_ok = (plain == 8'h20) || ((plain >= 8'h61) && (plain <= 8'h7a));

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      i           <= 8'd0;
      j           <= 8'd0;
      si          <= 8'd0;
      sj          <= 8'd0;
      enc_byte    <= 8'd0;
      k           <= '0;
      ok          <= 1'b1;
      s_address   <= 8'd0;
      s_data      <= 8'd0;
      s_wren      <= 1'b0;
      enc_address <= '0;
      dec_address <= '0;
      dec_data    <= 8'd0;
      dec_wren    <= 1'b0;
      finish      <= 1'b0;
      key_ok      <= 1'b0;
    end else begin
      // Write enables are single-cycle pulses.
      s_wren   <= 1'b0;
      dec_wren <= 1'b0;
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            i      <= 8'd1;
            j      <= 8'd0;
            k      <= '0;
            ok     <= 1'b1;
            finish <= 1'b0;
            key_ok <= 1'b0;
            state  <= RD_SI;
          end
        end
        RD_SI: begin
          s_address   <= i;
          enc_address <= k;
          state       <= WT_SI;
        end
        WT_SI: state <= RD_SJ;
        RD_SJ: begin
          si        <= s_q;
          enc_byte  <= enc_q;
          j         <= j + s_q;
          s_address <= j + s_q;
          state     <= WT_SJ;
        end
        WT_SJ: state <= WR_SI;
        WR_SI: begin
          sj        <= s_q;
          s_address <= i;
          s_data    <= s_q;
          s_wren    <= 1'b1;
          state     <= WR_SJ;
        end
        WR_SJ: begin
          // When i == j this rewrites the same location with the same value.
          s_address <= j;
          s_data    <= si;
          s_wren    <= 1'b1;
          state     <= RD_F;
        end
        RD_F: begin
          s_address <= si + sj;
          state     <= WT_F;
        end
        WT_F: state <= WR_DEC;
        WR_DEC: begin
          dec_address <= k;
          dec_data    <= plain;
          dec_wren    <= 1'b1;
          ok          <= ok & plain_ok;
          if (k == LAST_K) begin
            // finish is raised on the edge into DONE so it is visible there.
            finish <= 1'b1;
            key_ok <= ok & plain_ok;
            state  <= DONE;
          end else begin
            k     <= k + K_W'(1);
            i     <= i + 8'd1;
            state <= RD_SI;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rc4_prga_decrypt.sv
module tb_rc4_prga_decrypt;

  localparam int MSG = 9;
  localparam int KW  = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [7:0]    s_address, s_data, s_q;
  logic          s_wren;
  logic [KW-1:0] enc_address, dec_address;
  logic [7:0]    enc_q, dec_data;
  logic          dec_wren, finish, key_ok;

  always #5 clk = ~clk;

  rc4_prga_decrypt #(.MSG_LEN(MSG), .K_W(KW)) u_dut (
    .clk(clk), .rst(rst), .start(start),
    .s_address(s_address), .s_data(s_data), .s_wren(s_wren), .s_q(s_q),
    .enc_address(enc_address), .enc_q(enc_q),
    .dec_address(dec_address), .dec_data(dec_data), .dec_wren(dec_wren),
    .finish(finish), .key_ok(key_ok)
  );

  // synchronous memories: read data appears the cycle after the address
  logic [7:0] smem [256];
  logic [7:0] sload [256];
  logic [7:0] enc_rom [16];
  logic [7:0] dec_ram [16];
  bit         s_load = 1'b0;
  bit         dec_clr = 1'b0;

  always @(posedge clk) begin
    s_q   <= smem[s_address];
    enc_q <= enc_rom[enc_address];
    if (s_load) begin
      for (int x = 0; x < 256; x++) smem[x] <= sload[x];
    end else if (s_wren) begin
      smem[s_address] <= s_data;
    end
    if (dec_clr) begin
      for (int x = 0; x < 16; x++) dec_ram[x] <= 8'hee;
    end else if (dec_wren) begin
      dec_ram[dec_address] <= dec_data;
    end
  end

  int total = 0;
  int bad = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // reference model state
  logic [7:0]  ms [256];
  logic [7:0]  ms_save [256];
  logic [7:0]  menc [MSG];
  logic [7:0]  mplain [MSG];
  logic [7:0]  des [MSG];
  bit          mok;
  bit          legal [256];
  logic [15:0] mwr [$];

  logic [7:0] key [3]    = '{8'h4b, 8'h65, 8'h79};
  logic [7:0] kv_ct [9]  = '{8'hbb, 8'hf3, 8'h16, 8'he8, 8'hd9, 8'h40, 8'haf, 8'h0a, 8'hd3};
  logic [7:0] kv_pt [9]  = '{8'h50, 8'h6c, 8'h61, 8'h69, 8'h6e, 8'h74, 8'h65, 8'h78, 8'h74};
  logic [7:0] id_ks [4]  = '{8'h02, 8'h05, 8'h07, 8'h0d};

  function automatic bit in_set(input logic [7:0] b);
    return (b == 8'h20) || (b >= 8'h61 && b <= 8'h7a);
  endfunction

  // RC4 PRGA over the model S array
  function automatic void model_run();
    int i = 0, j = 0, si, sj, t;
    mok = 1'b1;
    mwr.delete();
    for (int x = 0; x < 256; x++) legal[x] = 1'b0;
    for (int n = 0; n < MSG; n++) begin
      i = (i + 1) % 256;
      si = ms[i];
      j = (j + si) % 256;
      sj = ms[j];
      ms[i] = sj[7:0];
      ms[j] = si[7:0];
      t = (si + sj) % 256;
      mplain[n] = ms[t] ^ menc[n];
      mok = mok & in_set(mplain[n]);
      mwr.push_back({i[7:0], sj[7:0]});
      mwr.push_back({j[7:0], si[7:0]});
      legal[i] = 1'b1;
      legal[j] = 1'b1;
      legal[t] = 1'b1;
    end
  endfunction

  function automatic void identity_s();
    for (int x = 0; x < 256; x++) ms[x] = x[7:0];
  endfunction

  function automatic void ksa_key();
    int j = 0;
    logic [7:0] tmp;
    identity_s();
    for (int x = 0; x < 256; x++) begin
      j = (j + ms[x] + key[x % 3]) % 256;
      tmp = ms[x];
      ms[x] = ms[j];
      ms[j] = tmp;
    end
  endfunction

  function automatic void shuffle_s();
    logic [7:0] tmp;
    int r;
    identity_s();
    for (int x = 255; x > 0; x--) begin
      r = $urandom_range(x, 0);
      tmp = ms[x];
      ms[x] = ms[r];
      ms[r] = tmp;
    end
  endfunction

  // choose ciphertext so the plaintext becomes des[] under the current S
  function automatic void make_enc_for_des();
    ms_save = ms;
    for (int n = 0; n < MSG; n++) menc[n] = 8'h00;
    model_run();
    for (int n = 0; n < MSG; n++) menc[n] = mplain[n] ^ des[n];
    ms = ms_save;
  endfunction

  task automatic prep(input bit reload);
    for (int n = 0; n < 16; n++) enc_rom[n] = (n < MSG) ? menc[n] : 8'h00;
    for (int x = 0; x < 256; x++) sload[x] = ms[x];
    @(negedge clk);
    s_load = reload;
    dec_clr = 1'b1;
    @(negedge clk);
    s_load = 1'b0;
    dec_clr = 1'b0;
  endtask

  // start pulse, per-cycle protocol monitor, then result checks
  task automatic run_and_check(input string tag, input int mid);
    int cnt = 0, wr_cnt = 0, dec_cnt = 0, dec_err = 0, bad_addr = 0, diffs = 0;
    logic [15:0] dwr [$];
    @(negedge clk);
    start = 1'b1;
    while (cnt < 2000) begin
      @(negedge clk);
      cnt++;
      if (cnt == 1) begin
        start = 1'b0;
        check_val({tag, "/fin_drop"}, 32'(finish), 0);
      end
      if (mid > 1 && cnt == mid) start = 1'b1;
      if (mid > 1 && cnt == mid + 1) start = 1'b0;
      if (s_wren) begin
        wr_cnt++;
        dwr.push_back({s_address, s_data});
      end
      if (dec_wren) begin
        if (32'(dec_address) != dec_cnt) dec_err++;
        dec_cnt++;
      end
      if (cnt >= 2 && finish) break;
      if (cnt >= 2 && !legal[s_address]) bad_addr++;
    end
    check_val({tag, "/latency"}, cnt, 1 + 9 * MSG);
    check_val({tag, "/key_ok"}, 32'(key_ok), 32'(mok));
    check_val({tag, "/s_wren_cnt"}, wr_cnt, 2 * MSG);
    check_val({tag, "/dec_wren_cnt"}, dec_cnt, MSG);
    check_val({tag, "/dec_addr_order"}, dec_err, 0);
    check_val({tag, "/s_addr_legal"}, bad_addr, 0);
    for (int n = 0; n < mwr.size(); n++)
      if (n < dwr.size()) check_val($sformatf("%s/swr%0d", tag, n), 32'(dwr[n]), 32'(mwr[n]));
    @(negedge clk);
    for (int n = 0; n < MSG; n++)
      check_val($sformatf("%s/pt%0d", tag, n), 32'(dec_ram[n]), 32'(mplain[n]));
    for (int x = 0; x < 256; x++) if (smem[x] !== ms[x]) diffs++;
    check_val({tag, "/s_final_diffs"}, diffs, 0);
  endtask

  initial begin
    for (int x = 0; x < 256; x++) smem[x] = 8'h00;
    for (int n = 0; n < 16; n++) begin
      enc_rom[n] = 8'h00;
      dec_ram[n] = 8'h00;
    end

    // reset state
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_val("rst/s_address", 32'(s_address), 0);
    check_val("rst/s_data", 32'(s_data), 0);
    check_val("rst/s_wren", 32'(s_wren), 0);
    check_val("rst/enc_address", 32'(enc_address), 0);
    check_val("rst/dec_address", 32'(dec_address), 0);
    check_val("rst/dec_data", 32'(dec_data), 0);
    check_val("rst/dec_wren", 32'(dec_wren), 0);
    check_val("rst/finish", 32'(finish), 0);
    check_val("rst/key_ok", 32'(key_ok), 0);
    rst = 1'b0;

    // reset asserted during WR_SI of the first byte
    identity_s();
    for (int n = 0; n < MSG; n++) menc[n] = 8'h00;
    prep(1'b1);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_val("midrst/s_wren", 32'(s_wren), 0);
    check_val("midrst/dec_wren", 32'(dec_wren), 0);
    check_val("midrst/finish", 32'(finish), 0);
    check_val("midrst/s_address", 32'(s_address), 0);
    repeat (12) @(negedge clk);
    check_val("midrst/idle_finish", 32'(finish), 0);
    check_val("midrst/idle_s_address", 32'(s_address), 0);

    // identity S, zero ciphertext: plaintext is the raw keystream
    identity_s();
    for (int n = 0; n < MSG; n++) menc[n] = 8'h00;
    prep(1'b1);
    model_run();
    run_and_check("ident", 0);
    for (int n = 0; n < 4; n++)
      check_val($sformatf("ident/ks%0d", n), 32'(dec_ram[n]), 32'(id_ks[n]));
    check_val("ident/key_ok_const", 32'(key_ok), 0);

    // known vector: key "Key", "Plaintext"
    ksa_key();
    for (int n = 0; n < MSG; n++) menc[n] = kv_ct[n];
    prep(1'b1);
    model_run();
    run_and_check("kv", 0);
    for (int n = 0; n < MSG; n++)
      check_val($sformatf("kv/const_pt%0d", n), 32'(dec_ram[n]), 32'(kv_pt[n]));
    check_val("kv/key_ok_const", 32'(key_ok), 0);

    // key_ok positive, including the set boundaries
    des = '{8'h61, 8'h62, 8'h20, 8'h7a, 8'h61, 8'h7a, 8'h20, 8'h6d, 8'h7a};
    identity_s();
    make_enc_for_des();
    prep(1'b1);
    model_run();
    run_and_check("okpos", 0);
    check_val("okpos/key_ok_const", 32'(key_ok), 1);

    // last byte just outside the set
    des[MSG-1] = 8'h7b;
    identity_s();
    make_enc_for_des();
    prep(1'b1);
    model_run();
    run_and_check("okneg", 0);
    check_val("okneg/key_ok_const", 32'(key_ok), 0);

    // restart from DONE on the permuted S, with a start pulse mid-run
    for (int n = 0; n < MSG; n++) menc[n] = 8'($urandom_range(255, 0));
    prep(1'b0);
    model_run();
    run_and_check("restart", 20);

    // randomized S permutations and ciphertexts
    for (int r = 0; r < 4; r++) begin
      shuffle_s();
      if (r % 2 == 1) begin
        for (int n = 0; n < MSG; n++)
          des[n] = ($urandom_range(3, 0) == 0) ? 8'h20 : 8'($urandom_range(8'h7a, 8'h61));
        make_enc_for_des();
      end else begin
        for (int n = 0; n < MSG; n++) menc[n] = 8'($urandom_range(255, 0));
      end
      prep(1'b1);
      model_run();
      run_and_check($sformatf("rand%0d", r), $urandom_range(70, 3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
